// File: rtl/inert_spi_resp.sv
// SPI slave register responder for an inertial sensor core.
// Decodes 16-bit SPI frames (R/W, 7-bit address, 8-bit data) against a small
// register map, holds the latest pitch-rate / Z-acceleration sample for
// readback and raises a data-ready interrupt when a new sample lands.
module inert_spi_resp (
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        INT,
   input  logic [15:0] ptch_rt,
   input  logic [15:0] az,
   input  logic        new_smpl,
   output logic        cfg_ok
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam logic [4:0] FRAME_BITS = 5'd16;
   localparam logic [4:0] ADDR_BITS  = 5'd8;
   localparam logic [7:0] WHO_AM_I   = 8'h6A;

   // Synchronizer chains: [0] is the first flop, [2] the edge-detect flop.
   logic [2:0]  ssSync_q;
   logic [2:0]  sclkSync_q;
   logic [1:0]  mosiSync_q;

   // Frame engine state.
   state_t      state_q;
   logic [4:0]  bitCnt_q;
   logic [15:0] rxShift_q;
   logic [7:0]  txShift_q;
   logic        miso_q;

   // Register file and sample path.
   logic [7:0]  cfg0D_q;
   logic [7:0]  cfg10_q;
   logic [7:0]  cfg11_q;
   logic [7:0]  cfg14_q;
   logic [15:0] heldPtch_q;
   logic [15:0] heldAz_q;
   logic [15:0] pendPtch_q;
   logic [15:0] pendAz_q;
   logic        pendFlag_q;
   logic        heldUpd_q;
   logic        int_q;
   logic        cfgOk_q;

   // Next-state values for the sample path and interrupt.
   logic [15:0] heldPtch_d;
   logic [15:0] heldAz_d;
   logic [15:0] pendPtch_d;
   logic [15:0] pendAz_d;
   logic        pendFlag_d;
   logic        heldLoad_d;
   logic        int_d;

   // Decoded events and helpers.
   logic        ssFall;
   logic        ssRise;
   logic        sclkRise;
   logic        sclkFall;
   logic        mosiBit;
   logic [6:0]  decodeAddr;
   logic [7:0]  readData;
   logic        commitWrite;
   logic        commitIntClr;
   logic        flushPoint;
   logic        intSetNow;
   logic        intSetNext;

   assign ssFall   =  ssSync_q[2] & ~ssSync_q[1];
   assign ssRise   = ~ssSync_q[2] &  ssSync_q[1];
   assign sclkRise = ~sclkSync_q[2] &  sclkSync_q[1];
   assign sclkFall =  sclkSync_q[2] & ~sclkSync_q[1];
   assign mosiBit  =  mosiSync_q[1];

   assign MISO   = miso_q;
   assign INT    = int_q;
   assign cfg_ok = cfgOk_q;

   // Bring the asynchronous SPI pins into the clk domain; idle levels on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ssSync_q   <= 3'b111;
         sclkSync_q <= 3'b111;
         mosiSync_q <= 2'b00;
      end else begin
         ssSync_q   <= {ssSync_q[1:0], SS_n};
         sclkSync_q <= {sclkSync_q[1:0], SCLK};
         mosiSync_q <= {mosiSync_q[0], MOSI};
      end
   end

   // Read mux: evaluated at the 8th SCLK rise, when the address's last bit
   // is arriving on MOSI and the R/W bit sits at rxShift_q[6].
   always_comb begin
      decodeAddr = {rxShift_q[5:0], mosiBit};
      readData   = 8'h00;
      case (decodeAddr)
         7'h0D:   readData = cfg0D_q;
         7'h0F:   readData = WHO_AM_I;
         7'h10:   readData = cfg10_q;
         7'h11:   readData = cfg11_q;
         7'h14:   readData = cfg14_q;
         7'h22:   readData = heldPtch_q[7:0];
         7'h23:   readData = heldPtch_q[15:8];
         7'h2C:   readData = heldAz_q[7:0];
         7'h2D:   readData = heldAz_q[15:8];
         default: readData = 8'h00;
      endcase
   end

   // Frame engine: shift MOSI in on SCLK rises, read data out on SCLK falls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bitCnt_q  <= 5'd0;
         rxShift_q <= 16'h0000;
         txShift_q <= 8'h00;
         miso_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               miso_q    <= 1'b0;
               txShift_q <= 8'h00;
               if (ssFall) begin
                  state_q   <= SHIFT;
                  bitCnt_q  <= 5'd0;
                  rxShift_q <= 16'h0000;
               end
            end
            SHIFT: begin
               if (ssRise) begin
                  miso_q  <= 1'b0;
                  state_q <= (bitCnt_q == FRAME_BITS) ? COMMIT : IDLE;
               end else begin
                  if (sclkRise && (bitCnt_q != FRAME_BITS)) begin
                     rxShift_q <= {rxShift_q[14:0], mosiBit};
                     bitCnt_q  <= bitCnt_q + 5'd1;
                     if (bitCnt_q == (ADDR_BITS - 5'd1)) begin
                        txShift_q <= rxShift_q[6] ? readData : 8'h00;
                     end
                  end
                  if (sclkFall && (bitCnt_q >= ADDR_BITS) && (bitCnt_q != FRAME_BITS)) begin
                     miso_q    <= txShift_q[7];
                     txShift_q <= {txShift_q[6:0], 1'b0};
                  end
               end
            end
            COMMIT: begin
               miso_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               miso_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Sample hand-off, frame-end actions and interrupt next state.
   always_comb begin
      commitWrite  = (state_q == COMMIT) && !rxShift_q[15];
      commitIntClr = (state_q == COMMIT) && rxShift_q[15] && (rxShift_q[14:8] == 7'h2D);
      flushPoint   = (state_q == COMMIT) ||
                     ((state_q == SHIFT) && ssRise && (bitCnt_q != FRAME_BITS));

      heldPtch_d = heldPtch_q;
      heldAz_d   = heldAz_q;
      heldLoad_d = 1'b0;
      if (new_smpl && ((state_q == IDLE) || flushPoint)) begin
         heldPtch_d = ptch_rt;
         heldAz_d   = az;
         heldLoad_d = 1'b1;
      end else if (flushPoint && pendFlag_q) begin
         heldPtch_d = pendPtch_q;
         heldAz_d   = pendAz_q;
         heldLoad_d = 1'b1;
      end

      pendPtch_d = pendPtch_q;
      pendAz_d   = pendAz_q;
      pendFlag_d = pendFlag_q;
      if (flushPoint) begin
         pendFlag_d = 1'b0;
      end else if (new_smpl && (state_q != IDLE)) begin
         pendPtch_d = ptch_rt;
         pendAz_d   = az;
         pendFlag_d = 1'b1;
      end

      // A sample landing at the same edge as the clear counts as a set, so
      // the clear is withheld and INT never glitches low.
      intSetNow  = heldUpd_q  & cfg0D_q[1];
      intSetNext = heldLoad_d & cfg0D_q[1];
      int_d      = intSetNow | (int_q & ~(commitIntClr & ~intSetNext));
   end

   // Config registers accept writes only in the commit cycle of a write frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg0D_q <= 8'h00;
         cfg10_q <= 8'h00;
         cfg11_q <= 8'h00;
         cfg14_q <= 8'h00;
      end else if (commitWrite) begin
         case (rxShift_q[14:8])
            7'h0D:   cfg0D_q <= rxShift_q[7:0];
            7'h10:   cfg10_q <= rxShift_q[7:0];
            7'h11:   cfg11_q <= rxShift_q[7:0];
            7'h14:   cfg14_q <= rxShift_q[7:0];
            default: ;
         endcase
      end
   end

   // Held/pending sample registers, interrupt and config-match flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         heldPtch_q <= 16'h0000;
         heldAz_q   <= 16'h0000;
         pendPtch_q <= 16'h0000;
         pendAz_q   <= 16'h0000;
         pendFlag_q <= 1'b0;
         heldUpd_q  <= 1'b0;
         int_q      <= 1'b0;
         cfgOk_q    <= 1'b0;
      end else begin
         heldPtch_q <= heldPtch_d;
         heldAz_q   <= heldAz_d;
         pendPtch_q <= pendPtch_d;
         pendAz_q   <= pendAz_d;
         pendFlag_q <= pendFlag_d;
         heldUpd_q  <= heldLoad_d;
         int_q      <= int_d;
         cfgOk_q    <= (cfg0D_q == 8'h02) && (cfg10_q == 8'h53) &&
                       (cfg11_q == 8'h50) && (cfg14_q == 8'h60);
      end
   end

endmodule

// File: tb/tb_inert_spi_resp.sv
// Directed testbench for inert_spi_resp: drives SPI frames bit by bit and
// compares MISO bytes, INT and cfg_ok against hand-computed values.
module tb_inert_spi_resp;

   logic        clk;
   logic        rst;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic        INT;
   logic [15:0] ptch_rt;
   logic [15:0] az;
   logic        new_smpl;
   logic        cfg_ok;

   int checks;
   int failures;

   inert_spi_resp dut (
      .clk      (clk),
      .rst      (rst),
      .SS_n     (SS_n),
      .SCLK     (SCLK),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .INT      (INT),
      .ptch_rt  (ptch_rt),
      .az       (az),
      .new_smpl (new_smpl),
      .cfg_ok   (cfg_ok)
   );

   // 100 MHz system clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the bench can never hang.
   initial begin
      #3000000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

   // One SPI transfer. nBits rises are sent; if endFrame, SS_n is raised and
   // twelve clks are observed (INT watched, optional new_smpl in COMMIT).
   // pulseBit selects the bit index k (0-based) whose low phase carries a
   // one-clk new_smpl pulse; -1 disables it.
   task automatic spiXfer(input logic [15:0] txWord, input int nBits, input bit endFrame,
                          input int pulseBit, input bit pulseAtCommit,
                          output logic [15:0] rxWord, output bit sawIntLow);
      rxWord    = 16'h0000;
      sawIntLow = 1'b0;
      @(posedge clk); #1;
      SS_n = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      for (int k = 0; k < nBits; k++) begin
         SCLK = 1'b0;
         MOSI = txWord[15-k];
         for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            new_smpl = (k == pulseBit) && (c == 0);
         end
         rxWord[15-k] = MISO;
         SCLK = 1'b1;
         repeat (8) @(posedge clk);
         #1;
      end
      if (endFrame) begin
         SS_n = 1'b1;
         for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            new_smpl = pulseAtCommit && (c == 2);
            if (INT == 1'b0) sawIntLow = 1'b1;
         end
      end
   endtask

   task automatic spiFrame(input logic [15:0] txWord, output logic [15:0] rxWord);
      bit dummy;
      spiXfer(txWord, 16, 1'b1, -1, 1'b0, rxWord, dummy);
   endtask

   task automatic pulseSample(input logic [15:0] p, input logic [15:0] a);
      @(posedge clk); #1;
      ptch_rt  = p;
      az       = a;
      new_smpl = 1'b1;
      @(posedge clk); #1;
      new_smpl = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
      new_smpl = 1'b0; ptch_rt = 16'h0000; az = 16'h0000;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (MISO !== 1'b0) begin failures++; $display("[TB] FAIL reset_miso got=%b want=0", MISO); end
      checks++; if (INT !== 1'b0) begin failures++; $display("[TB] FAIL reset_int got=%b want=0", INT); end
      checks++; if (cfg_ok !== 1'b0) begin failures++; $display("[TB] FAIL reset_cfgok got=%b want=0", cfg_ok); end
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_config_write();
      logic [15:0] r;
      spiFrame(16'h0D02, r);
      spiFrame(16'h1053, r);
      spiFrame(16'h1150, r);
      checks++; if (cfg_ok !== 1'b0) begin failures++; $display("[TB] FAIL cfgok_3of4 got=%b want=0", cfg_ok); end
      spiFrame(16'h1460, r);
      checks++; if (cfg_ok !== 1'b1) begin failures++; $display("[TB] FAIL cfgok_4of4 got=%b want=1", cfg_ok); end
      spiFrame(16'h8D00, r);
      checks++; if (r !== 16'h0002) begin failures++; $display("[TB] FAIL rd_0D got=%h want=0002", r); end
      spiFrame(16'h9000, r);
      checks++; if (r !== 16'h0053) begin failures++; $display("[TB] FAIL rd_10 got=%h want=0053", r); end
      spiFrame(16'h9100, r);
      checks++; if (r !== 16'h0050) begin failures++; $display("[TB] FAIL rd_11 got=%h want=0050", r); end
      spiFrame(16'h9400, r);
      checks++; if (r !== 16'h0060) begin failures++; $display("[TB] FAIL rd_14 got=%h want=0060", r); end
   endtask

   task automatic test_whoami();
      logic [15:0] r;
      spiFrame(16'h8FA5, r);
      checks++; if (r !== 16'h006A) begin failures++; $display("[TB] FAIL rd_whoami got=%h want=006A", r); end
      spiFrame(16'h8055, r);
      checks++; if (r !== 16'h0000) begin failures++; $display("[TB] FAIL rd_unmapped got=%h want=0000", r); end
      spiFrame(16'h3077, r);
      spiFrame(16'hB000, r);
      checks++; if (r !== 16'h0000) begin failures++; $display("[TB] FAIL wr_unmapped_ignored got=%h want=0000", r); end
   endtask

   task automatic test_sample_int();
      logic [15:0] r;
      @(posedge clk); #1;
      ptch_rt  = 16'h1234;
      az       = 16'hFEDC;
      new_smpl = 1'b1;
      @(posedge clk); #1;
      new_smpl = 1'b0;
      checks++; if (INT !== 1'b0) begin failures++; $display("[TB] FAIL int_early got=%b want=0", INT); end
      @(posedge clk); #1;
      checks++; if (INT !== 1'b1) begin failures++; $display("[TB] FAIL int_set got=%b want=1", INT); end
      spiFrame(16'hA200, r);
      checks++; if (r !== 16'h0034) begin failures++; $display("[TB] FAIL rd_22 got=%h want=0034", r); end
      spiFrame(16'hA300, r);
      checks++; if (r !== 16'h0012) begin failures++; $display("[TB] FAIL rd_23 got=%h want=0012", r); end
      spiFrame(16'hAC00, r);
      checks++; if (r !== 16'h00DC) begin failures++; $display("[TB] FAIL rd_2C got=%h want=00DC", r); end
      checks++; if (INT !== 1'b1) begin failures++; $display("[TB] FAIL int_hold_2C got=%b want=1", INT); end
      spiFrame(16'hAD00, r);
      checks++; if (r !== 16'h00FE) begin failures++; $display("[TB] FAIL rd_2D got=%h want=00FE", r); end
      checks++; if (INT !== 1'b0) begin failures++; $display("[TB] FAIL int_clear got=%b want=0", INT); end
   endtask

   task automatic test_no_int();
      logic [15:0] r;
      spiFrame(16'h0D00, r);
      checks++; if (cfg_ok !== 1'b0) begin failures++; $display("[TB] FAIL cfgok_drop got=%b want=0", cfg_ok); end
      pulseSample(16'h0BCD, 16'h0777);
      repeat (4) @(posedge clk);
      #1;
      checks++; if (INT !== 1'b0) begin failures++; $display("[TB] FAIL int_masked got=%b want=0", INT); end
      spiFrame(16'hA200, r);
      checks++; if (r !== 16'h00CD) begin failures++; $display("[TB] FAIL rd_22_masked got=%h want=00CD", r); end
      spiFrame(16'hAD00, r);
      checks++; if (r !== 16'h0007) begin failures++; $display("[TB] FAIL rd_2D_masked got=%h want=0007", r); end
   endtask

   task automatic test_abort();
      logic [15:0] r;
      bit          lowSeen;
      spiXfer(16'h1099, 10, 1'b1, -1, 1'b0, r, lowSeen);
      spiFrame(16'h9000, r);
      checks++; if (r !== 16'h0053) begin failures++; $display("[TB] FAIL abort_no_write got=%h want=0053", r); end
      ptch_rt = 16'h5555;
      az      = 16'h5555;
      spiXfer(16'hA200, 16, 1'b1, 4, 1'b0, r, lowSeen);
      checks++; if (r !== 16'h00CD) begin failures++; $display("[TB] FAIL pend_not_early got=%h want=00CD", r); end
      spiFrame(16'hA200, r);
      checks++; if (r !== 16'h0055) begin failures++; $display("[TB] FAIL pend_flush_22 got=%h want=0055", r); end
      spiFrame(16'hAD00, r);
      checks++; if (r !== 16'h0055) begin failures++; $display("[TB] FAIL pend_flush_2D got=%h want=0055", r); end
      checks++; if (INT !== 1'b0) begin failures++; $display("[TB] FAIL int_masked_pend got=%b want=0", INT); end
   endtask

   task automatic test_set_wins();
      logic [15:0] r;
      bit          lowSeen;
      spiFrame(16'h0D02, r);
      checks++; if (cfg_ok !== 1'b1) begin failures++; $display("[TB] FAIL cfgok_restore got=%b want=1", cfg_ok); end
      pulseSample(16'h1111, 16'h2222);
      checks++; if (INT !== 1'b1) begin failures++; $display("[TB] FAIL int_set2 got=%b want=1", INT); end
      ptch_rt = 16'h3333;
      az      = 16'h4444;
      spiXfer(16'hAD00, 16, 1'b1, -1, 1'b1, r, lowSeen);
      checks++; if (r !== 16'h0022) begin failures++; $display("[TB] FAIL rd_2D_setwins got=%h want=0022", r); end
      checks++; if (lowSeen !== 1'b0) begin failures++; $display("[TB] FAIL int_setwins_glitch got=%b want=0", lowSeen); end
      checks++; if (INT !== 1'b1) begin failures++; $display("[TB] FAIL int_setwins got=%b want=1", INT); end
      spiFrame(16'hA200, r);
      checks++; if (r !== 16'h0033) begin failures++; $display("[TB] FAIL rd_22_commit_load got=%h want=0033", r); end
      spiFrame(16'h0D00, r);
      checks++; if (INT !== 1'b1) begin failures++; $display("[TB] FAIL int_sticky_mask got=%b want=1", INT); end
      spiFrame(16'hAD00, r);
      checks++; if (r !== 16'h0044) begin failures++; $display("[TB] FAIL rd_2D_final got=%h want=0044", r); end
      checks++; if (INT !== 1'b0) begin failures++; $display("[TB] FAIL int_clear2 got=%b want=0", INT); end
   endtask

   task automatic test_reset_midframe();
      logic [15:0] r;
      bit          lowSeen;
      spiFrame(16'h0D02, r);
      pulseSample(16'h0101, 16'h0202);
      checks++; if ((INT !== 1'b1) || (cfg_ok !== 1'b1)) begin
         failures++; $display("[TB] FAIL pre_rst_state got int=%b cfgok=%b want 1 1", INT, cfg_ok);
      end
      spiXfer(16'h8F00, 10, 1'b0, -1, 1'b0, r, lowSeen);
      checks++; if (MISO !== 1'b1) begin failures++; $display("[TB] FAIL miso_bit6 got=%b want=1", MISO); end
      rst = 1'b1;
      #2;
      checks++; if ({MISO, INT, cfg_ok} !== 3'b000) begin
         failures++; $display("[TB] FAIL rst_midframe got=%b want=000", {MISO, INT, cfg_ok});
      end
      SS_n = 1'b1;
      SCLK = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      spiFrame(16'h8F00, r);
      checks++; if (r !== 16'h006A) begin failures++; $display("[TB] FAIL rd_after_rst got=%h want=006A", r); end
      spiFrame(16'h8D00, r);
      checks++; if (r !== 16'h0000) begin failures++; $display("[TB] FAIL cfg_after_rst got=%h want=0000", r); end
      checks++; if ({INT, cfg_ok} !== 2'b00) begin
         failures++; $display("[TB] FAIL out_after_rst got=%b want=00", {INT, cfg_ok});
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_config_write();
      test_whoami();
      test_sample_int();
      test_no_int();
      test_abort();
      test_set_wins();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inert_spi_resp.md
INERT_SPI_RESP -- requirements
Module: inert_spi_resp

Interface
REQ-001 clk  input  1  system clock; all logic on its rising edge; one clock domain.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 SS_n  input  1  SPI slave select, active low, asynchronous to clk.
REQ-004 SCLK  input  1  SPI clock: idle high; master drives on fall, samples on rise; asynchronous to clk.
REQ-005 MOSI  input  1  SPI data from master, MSB first.
REQ-006 MISO  output  1  SPI data to master, MSB first; always driven, never tri-stated.
REQ-007 INT  output  1  data-ready interrupt, active high, registered.
REQ-008 ptch_rt  input  16  signed pitch-rate sample from the sensor core.
REQ-009 az  input  16  signed Z-acceleration sample from the sensor core.
REQ-010 new_smpl  input  1  one-clk pulse: ptch_rt/az valid this cycle.
REQ-011 cfg_ok  output  1  high while regs 0x0D=0x02, 0x10=0x53, 0x11=0x50, 0x14=0x60.

Function
REQ-012 SS_n, SCLK, MOSI shall each pass through a 2-flop synchronizer; SCLK/SS_n edges are detected from a third flop; SCLK period >= 16 clk and SS_n setup/hold >= 4 clk are guaranteed by the master.
REQ-013 Frame = 16 bits: bit15 R/W (1=read), bits14:8 address, bits7:0 write data (don't-care on read).
REQ-014 FSM states: IDLE, SHIFT, COMMIT.
REQ-015 IDLE->SHIFT on SS_n fall; bit counter (5-bit) cleared; rx shift register cleared.
REQ-016 SHIFT: each SCLK rise shifts synchronized MOSI into rx LSB and increments the counter; rises beyond 16 are ignored (counter saturates at 16).
REQ-017 SHIFT->COMMIT on SS_n rise when counter==16; SHIFT->IDLE on SS_n rise when counter!=16 (frame discarded: no write, no INT clear).
REQ-018 COMMIT lasts exactly 1 clk and always returns to IDLE.
REQ-019 MISO shall output 0 during bits 15:8 of every frame and while SS_n is high.
REQ-020 On a read, the address shall be decoded at the 8th SCLK rise; read-data bit 7 shall be on MISO from the next SCLK fall, bit 0 after the 15th fall.
REQ-021 Read map: 0x0D/0x10/0x11/0x14 config regs; 0x0F returns 0x6A; 0x22/0x23 held ptch_rt low/high byte; 0x2C/0x2D held az low/high byte; all other addresses return 0x00.
REQ-022 Write in COMMIT only (bit15=0): 0x0D, 0x10, 0x11, 0x14 take bits7:0; writes to any other address are ignored.
REQ-023 new_smpl while FSM in IDLE: held regs load ptch_rt/az the next clk.
REQ-024 new_smpl while in SHIFT/COMMIT: sample captured into a pending buffer with a pending flag; held regs update in the COMMIT cycle or the IDLE-return cycle; a newer pulse overwrites the pending buffer.
REQ-025 INT shall set 1 clk after held regs update, only if reg 0x0D bit1 = 1.
REQ-026 INT shall clear in COMMIT of a complete read of address 0x2D.
REQ-027 Set and clear in the same cycle: set wins, so INT stays 1.
REQ-028 Clearing reg 0x0D bit1 shall not clear an INT that is already asserted.
REQ-029 cfg_ok shall be a registered compare and update 1 clk after the config write.

Reset
REQ-030 On rst: FSM=IDLE, counter=0, rx/tx shift regs=0, config regs=0x00, held/pending regs=0, pending flag=0, INT=0, MISO=0, cfg_ok=0.
REQ-031 Synchronizer flops reset to SS_n=1, SCLK=1, MOSI=0.
REQ-032 rst mid-frame: the frame is abandoned; the next frame is recognized only after a new SS_n fall.

Verification
REQ-033 Write frames 0x0D02, 0x1053, 0x1150, 0x1460 -> reads of 0x0D/0x10/0x11/0x14 return 02/53/50/60; cfg_ok=1 after the 4th commit.
REQ-034 Frame 0x8Fxx -> MISO byte bits7:0 = 0x6A, bits15:8 = 0x00.
REQ-035 0x0D=0x02, new_smpl with ptch_rt=0x1234, az=0xFEDC -> INT=1; reads 0xA2/0xA3/0xAC/0xAD return 34/12/DC/FE; INT=0 after the 0xAD commit.
REQ-036 0x0D=0x00, new_smpl -> INT stays 0; held regs still update.
REQ-037 SS_n raised after 10 bits of write 0x1099 -> reg 0x10 unchanged; new_smpl mid-frame (0x5555) -> held regs unchanged until frame end, then 0x5555.
REQ-038 new_smpl in the same cycle as the 0xAD commit -> INT remains 1; rst asserted mid-frame -> all outputs 0; a following full frame decodes correctly.
